// File: rtl/smart_ssr_scheduler_if.sv
// Request/grant bundle between an output port's SSR sources and its scheduler.
interface smart_ssr_scheduler_if #(
  parameter int unsigned HPC_MAX  = 4,
  parameter int unsigned CREDIT_W = 3,
  parameter int unsigned LEN_W    = 3
);
  logic                local_req;
  logic [LEN_W-1:0]    local_len;
  logic [HPC_MAX-1:0]  ssr_valid;
  logic                credit_in;
  logic                local_gnt;
  logic [HPC_MAX-1:0]  ssr_gnt;
  logic                bypass_en;
  logic [HPC_MAX-1:0]  ssr_bcast;
  logic                out_valid;
  logic [CREDIT_W-1:0] credit_cnt;
  logic                credit_err;

  modport master (
    output local_req, local_len, ssr_valid, credit_in,
    input  local_gnt, ssr_gnt, bypass_en, ssr_bcast, out_valid, credit_cnt, credit_err
  );

  modport slave (
    input  local_req, local_len, ssr_valid, credit_in,
    output local_gnt, ssr_gnt, bypass_en, ssr_bcast, out_valid, credit_cnt, credit_err
  );
endinterface

// File: rtl/smart_ssr_scheduler.sv
// Per-output-port SMART SSR arbiter: prioritised local/SSR grant, credit gating
// and a starvation counter that periodically forces an SSR through.
module smart_ssr_scheduler #(
  parameter int unsigned HPC_MAX      = 4,
  parameter int unsigned CREDITS      = 4,
  parameter int unsigned CREDIT_W     = 3,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned LEN_W        = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  smart_ssr_scheduler_if.slave  bus
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

  logic [1:0]          state_q, state_d;
  logic                lgnt_q, lgnt_d;
  logic [HPC_MAX-1:0]  sgnt_q, sgnt_d;
  logic [HPC_MAX-1:0]  bcast_q, bcast_d;
  logic                oval_q, oval_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                err_q, err_d;
  logic [SW-1:0]       starve_q, starve_d;

  logic                have_credit;
  logic                any_ssr;
  logic                force_ssr;
  logic                found;
  logic                grant;
  logic [HPC_MAX-1:0]  ssr_pick;
  int unsigned         len_u;

  always_comb begin
    have_credit = (credit_q != '0);
    any_ssr     = |bus.ssr_valid;
    force_ssr   = (starve_q == SW'(STARVE_LIMIT)) && any_ssr;

    // Lowest index is the nearest upstream router, hence highest SSR priority.
    ssr_pick = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < HPC_MAX; i++) begin
      if (bus.ssr_valid[i] && !found) begin
        ssr_pick[i] = 1'b1;
        found       = 1'b1;
      end
    end

    lgnt_d = 1'b0;
    sgnt_d = '0;
    if (have_credit) begin
      if (bus.local_req && !force_ssr) lgnt_d = 1'b1;
      else                             sgnt_d = ssr_pick;
    end
    grant  = lgnt_d | (|sgnt_d);
    oval_d = lgnt_q | (|sgnt_q);

    len_u = 32'(bus.local_len);
    if (len_u > HPC_MAX) len_u = HPC_MAX;
    bcast_d = '0;
    if (lgnt_d) begin
      for (int unsigned j = 0; j < HPC_MAX; j++) bcast_d[j] = (j < len_u);
    end

    // A grant always has a credit behind it, so the decrement cannot wrap.
    credit_d = credit_q;
    err_d    = err_q;
    if (grant && !bus.credit_in) begin
      credit_d = credit_q - 1'b1;
    end else if (bus.credit_in && !grant) begin
      if (credit_q == CREDIT_W'(CREDITS)) err_d    = 1'b1;
      else                                credit_d = credit_q + 1'b1;
    end

    starve_d = starve_q;
    if (|sgnt_d)
      starve_d = '0;
    else if (lgnt_d && any_ssr && starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + 1'b1;

    if (grant)                              state_d = GRANT;
    else if (bus.local_req || any_ssr)      state_d = STALL;
    else                                    state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lgnt_q   <= 1'b0;
      sgnt_q   <= '0;
      bcast_q  <= '0;
      oval_q   <= 1'b0;
      credit_q <= CREDIT_W'(CREDITS);
      err_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      lgnt_q   <= lgnt_d;
      sgnt_q   <= sgnt_d;
      bcast_q  <= bcast_d;
      oval_q   <= oval_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      starve_q <= starve_d;
    end
  end

  assign bus.local_gnt  = lgnt_q;
  assign bus.ssr_gnt    = sgnt_q;
  assign bus.bypass_en  = |sgnt_q;
  assign bus.ssr_bcast  = bcast_q;
  assign bus.out_valid  = oval_q;
  assign bus.credit_cnt = credit_q;
  assign bus.credit_err = err_q;

endmodule

// File: tb/tb_smart_ssr_scheduler.sv
// Directed scoreboard bench for smart_ssr_scheduler.
module tb_smart_ssr_scheduler;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  typedef struct {
    logic       lg;
    logic [3:0] sg;
    logic [3:0] bc;
    logic [2:0] cc;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic last_grant = 1'b0;
  exp_t exp_q[$];

  smart_ssr_scheduler_if #(.HPC_MAX(4), .CREDIT_W(3), .LEN_W(3)) bus ();

  smart_ssr_scheduler #(
    .HPC_MAX(4), .CREDITS(4), .CREDIT_W(3), .STARVE_LIMIT(8), .LEN_W(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic lr, input logic [2:0] len, input logic [3:0] ssr, input logic ci);
    bus.local_req = lr;
    bus.local_len = len;
    bus.ssr_valid = ssr;
    bus.credit_in = ci;
  endtask

  task automatic push_exp(input logic lg, input logic [3:0] sg, input logic [3:0] bc,
                          input logic [2:0] cc, input logic err);
    exp_t e;
    e.lg = lg; e.sg = sg; e.bc = bc; e.cc = cc; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_local_gnt"},  32'(bus.local_gnt),  32'(e.lg));
      chk({tag, "_ssr_gnt"},    32'(bus.ssr_gnt),    32'(e.sg));
      chk({tag, "_bypass_en"},  32'(bus.bypass_en),  32'(|e.sg));
      chk({tag, "_ssr_bcast"},  32'(bus.ssr_bcast),  32'(e.bc));
      chk({tag, "_credit_cnt"}, 32'(bus.credit_cnt), 32'(e.cc));
      chk({tag, "_credit_err"}, 32'(bus.credit_err), 32'(e.err));
      chk({tag, "_out_valid"},  32'(bus.out_valid),  32'(last_grant));
      last_grant = e.lg | (|e.sg);
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 3'd0, 4'b0000, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    last_grant = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    drive(1'b0, 3'd0, 4'b0000, 1'b0);
    do_reset();

    // Test 1: asynchronous reset in the middle of a grant
    drive(1'b1, 3'd1, 4'b0000, 1'b0);
    push_exp(1'b1, 4'b0000, 4'b0001, 3'd3, 1'b0);
    tick("t1_pre");
    rst_n = 1'b0;
    #1;
    chk("t1_rst_local_gnt",  32'(bus.local_gnt),  32'd0);
    chk("t1_rst_ssr_gnt",    32'(bus.ssr_gnt),    32'd0);
    chk("t1_rst_bypass",     32'(bus.bypass_en),  32'd0);
    chk("t1_rst_bcast",      32'(bus.ssr_bcast),  32'd0);
    chk("t1_rst_out_valid",  32'(bus.out_valid),  32'd0);
    chk("t1_rst_credit_cnt", 32'(bus.credit_cnt), 32'd4);
    chk("t1_rst_credit_err", 32'(bus.credit_err), 32'd0);
    do_reset();
    push_exp(1'b0, 4'b0000, 4'b0000, 3'd4, 1'b0);
    tick("t1_post");

    // Test 2/3: local beats SSRs, then nearest SSR wins alone
    do_reset();
    drive(1'b1, 3'd2, 4'b0110, 1'b0);
    push_exp(1'b1, 4'b0000, 4'b0011, 3'd3, 1'b0);
    tick("t2_local");
    drive(1'b0, 3'd2, 4'b0110, 1'b0);
    push_exp(1'b0, 4'b0010, 4'b0000, 3'd2, 1'b0);
    tick("t3_ssr");
    drive(1'b0, 3'd0, 4'b0000, 1'b0);
    push_exp(1'b0, 4'b0000, 4'b0000, 3'd2, 1'b0);
    tick("t3_idle0");
    push_exp(1'b0, 4'b0000, 4'b0000, 3'd2, 1'b0);
    tick("t3_idle1");

    // Test 4: credit exhaustion, stall, single credit return
    do_reset();
    drive(1'b1, 3'd1, 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      push_exp(1'b1, 4'b0000, 4'b0001, 3'(3 - k), 1'b0);
      tick("t4_drain");
    end
    push_exp(1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0);
    tick("t4_stall");
    chk("t4_state_stall", 32'(dut.state_q), 32'(S_STALL));
    drive(1'b1, 3'd1, 4'b0000, 1'b1);
    push_exp(1'b0, 4'b0000, 4'b0000, 3'd1, 1'b0);
    tick("t4_ret");
    chk("t4_state_still_stall", 32'(dut.state_q), 32'(S_STALL));
    drive(1'b1, 3'd1, 4'b0000, 1'b0);
    push_exp(1'b1, 4'b0000, 4'b0001, 3'd0, 1'b0);
    tick("t4_regrant");
    chk("t4_state_grant", 32'(dut.state_q), 32'(S_GRANT));
    push_exp(1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0);
    tick("t4_stall2");
    drive(1'b0, 3'd0, 4'b0000, 1'b0);
    push_exp(1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0);
    tick("t4_withdraw");
    chk("t4_state_idle", 32'(dut.state_q), 32'(S_IDLE));

    // Test 5: starvation forcing; len 7 clamps to full broadcast
    do_reset();
    drive(1'b1, 3'd7, 4'b1000, 1'b1);
    for (int k = 0; k < 8; k++) begin
      push_exp(1'b1, 4'b0000, 4'b1111, 3'd4, 1'b0);
      tick("t5_local");
    end
    push_exp(1'b0, 4'b1000, 4'b0000, 3'd4, 1'b0);
    tick("t5_forced");
    push_exp(1'b1, 4'b0000, 4'b1111, 3'd4, 1'b0);
    tick("t5_local_again");

    // Test 6: overflow error is sticky; grant+return holds count
    do_reset();
    drive(1'b0, 3'd0, 4'b0000, 1'b1);
    push_exp(1'b0, 4'b0000, 4'b0000, 3'd4, 1'b1);
    tick("t6_ovf");
    drive(1'b0, 3'd0, 4'b0000, 1'b0);
    push_exp(1'b0, 4'b0000, 4'b0000, 3'd4, 1'b1);
    tick("t6_sticky");
    drive(1'b1, 3'd1, 4'b0000, 1'b0);
    push_exp(1'b1, 4'b0000, 4'b0001, 3'd3, 1'b1);
    tick("t6_g1");
    push_exp(1'b1, 4'b0000, 4'b0001, 3'd2, 1'b1);
    tick("t6_g2");
    drive(1'b1, 3'd1, 4'b0000, 1'b1);
    push_exp(1'b1, 4'b0000, 4'b0001, 3'd2, 1'b1);
    tick("t6_simul");
    drive(1'b0, 3'd0, 4'b1100, 1'b0);
    push_exp(1'b0, 4'b0100, 4'b0000, 3'd1, 1'b1);
    tick("t6_ssr_prio");
    drive(1'b0, 3'd0, 4'b0000, 1'b0);
    push_exp(1'b0, 4'b0000, 4'b0000, 3'd1, 1'b1);
    tick("t6_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
